// File: rtl/inst_fifo_dual.sv
// Dual-issue instruction queue between the 2-wide i-cache fetch stage and
// decode: accepts 0/1/2 instructions per cycle and presents the two oldest.
module inst_fifo_dual #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        write_en1,
   input  logic        write_en2,
   input  logic [31:0] write_inst1,
   input  logic [31:0] write_inst2,
   input  logic [31:0] write_pc,
   input  logic        read_en1,
   input  logic        read_en2,
   output logic [31:0] read_inst1,
   output logic [31:0] read_inst2,
   output logic [31:0] read_pc1,
   output logic [31:0] read_pc2,
   output logic        valid1,
   output logic        valid2,
   output logic        empty,
   output logic        full
);

   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      inst_q [DEPTH];
   logic [31:0]      inst_d [DEPTH];
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      pc_d   [DEPTH];

   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] wptr_d;
   logic [PTR_W-1:0] rptr_q;
   logic [PTR_W-1:0] rptr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic [PTR_W-1:0] wptr_inc;
   logic [PTR_W-1:0] rptr_inc;
   logic [1:0]       nwrite;
   logic [1:0]       nread;

   // Pointers are PTR_W wide, so +1 wraps mod DEPTH on its own.
   assign wptr_inc = wptr_q + PTR_W'(1);
   assign rptr_inc = rptr_q + PTR_W'(1);

   assign valid1 = (count_q != '0);
   assign valid2 = (count_q >= CNT_W'(2));
   assign empty  = (count_q == '0);
   assign full   = (count_q >= CNT_W'(DEPTH - 1));

   assign read_inst1 = valid1 ? inst_q[rptr_q]   : '0;
   assign read_pc1   = valid1 ? pc_q[rptr_q]     : '0;
   assign read_inst2 = valid2 ? inst_q[rptr_inc] : '0;
   assign read_pc2   = valid2 ? pc_q[rptr_inc]   : '0;

   always_comb begin
      nwrite = 2'd0;
      if (!full) begin
         if (write_en1 && write_en2) begin
            nwrite = 2'd2;
         end else if (write_en1) begin
            nwrite = 2'd1;
         end
      end
   end

   always_comb begin
      nread = 2'd0;
      if (read_en1 && valid1) begin
         nread = (read_en2 && valid2) ? 2'd2 : 2'd1;
      end
   end

   always_comb begin
      inst_d = inst_q;
      pc_d   = pc_q;
      if (!flush && nwrite != 2'd0) begin
         inst_d[wptr_q] = write_inst1;
         pc_d[wptr_q]   = write_pc;
         if (nwrite == 2'd2) begin
            inst_d[wptr_inc] = write_inst2;
            pc_d[wptr_inc]   = write_pc + 32'd4;
         end
      end
   end

   always_comb begin
      wptr_d  = wptr_q + PTR_W'(nwrite);
      rptr_d  = rptr_q + PTR_W'(nread);
      count_d = count_q + CNT_W'(nwrite) - CNT_W'(nread);
      // Redirect discards everything, including this cycle's traffic.
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
   end

endmodule

// File: tb/tb_inst_fifo_dual.sv
// Randomized and directed bench for inst_fifo_dual against a queue model.
module tb_inst_fifo_dual;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        we1 = 1'b0;
   logic        we2 = 1'b0;
   logic [31:0] wi1 = '0;
   logic [31:0] wi2 = '0;
   logic [31:0] wpc = '0;
   logic        re1 = 1'b0;
   logic        re2 = 1'b0;
   logic [31:0] ri1, ri2, rp1, rp2;
   logic        v1, v2, emp, ful;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] mq[$];
   int          mw = 0;
   int          mr = 0;

   inst_fifo_dual #(.DEPTH(DEPTH), .PTR_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .write_en1(we1), .write_en2(we2),
      .write_inst1(wi1), .write_inst2(wi2), .write_pc(wpc),
      .read_en1(re1), .read_en2(re2),
      .read_inst1(ri1), .read_inst2(ri2),
      .read_pc1(rp1), .read_pc2(rp2),
      .valid1(v1), .valid2(v2), .empty(emp), .full(ful)
   );

   always #5 clk = ~clk;

   // Reference: a list of {inst,pc}, oldest first.
   task automatic model_step();
      int sz;
      bit is_full;
      int nr;
      sz = mq.size();
      if (rst || flush) begin
         mq.delete();
         mw = 0;
         mr = 0;
         return;
      end
      is_full = (DEPTH - sz) < 2;
      nr = 0;
      if (re1 && sz >= 1) nr = (re2 && sz >= 2) ? 2 : 1;
      for (int k = 0; k < nr; k++) void'(mq.pop_front());
      mr += nr;
      if (!is_full && we1) begin
         mq.push_back({wi1, wpc});
         mw++;
         if (we2) begin
            mq.push_back({wi2, wpc + 32'd4});
            mw++;
         end
      end
   endtask

   function automatic logic [131:0] exp_vec();
      logic [31:0] i1, p1, i2, p2;
      int sz;
      sz = mq.size();
      i1 = '0; p1 = '0; i2 = '0; p2 = '0;
      if (sz >= 1) {i1, p1} = mq[0];
      if (sz >= 2) {i2, p2} = mq[1];
      return {sz >= 1, sz >= 2, sz == 0, (DEPTH - sz) < 2, i1, p1, i2, p2};
   endfunction

   function automatic logic [131:0] dut_vec();
      return {v1, v2, emp, ful, ri1, rp1, ri2, rp2};
   endfunction

   task automatic idle();
      rst = 0; flush = 0; we1 = 0; we2 = 0; re1 = 0; re2 = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wr2(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc);
      we1 = 1; we2 = 1; wi1 = a; wi2 = b; wpc = pc;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && mq.size() > 0; k++) begin
         idle(); re1 = 1; re2 = 1;
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      tick();
      if (dut_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset_in: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      idle();
      for (int k = 0; k < 5; k++) begin
         tick();
         if (dut_vec() !== exp_vec() || ri1 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_idle%0d: got %h want %h", k,
                     dut_vec(), exp_vec());
         end
         n_cmp++;
      end
   endtask

   task automatic test_dual_write();
      idle(); wr2(32'h11111111, 32'h22222222, 32'hBFC00000);
      tick(); idle();
      if (dut_vec() !== exp_vec() || rp1 !== 32'hBFC00000 ||
          rp2 !== 32'hBFC00004 || v2 !== 1'b1) begin
         n_bad++;
         $display("FAIL dual_write: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      re1 = 1;
      tick(); idle();
      if (dut_vec() !== exp_vec() || ri1 !== 32'h22222222 || v2 !== 1'b0)
      begin
         n_bad++;
         $display("FAIL single_read: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      drain();
   endtask

   task automatic test_fill();
      for (int k = 0; k < 7; k++) begin
         idle(); wr2(32'h100 + k * 2, 32'h101 + k * 2, 32'h1000 + k * 8);
         tick();
      end
      idle(); we1 = 1; wi1 = 32'h1FF; wpc = 32'h2000;
      tick(); idle();
      if (dut_vec() !== exp_vec() || ful !== 1'b1) begin
         n_bad++;
         $display("FAIL fill_full: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      wr2(32'hDEAD0001, 32'hDEAD0002, 32'h3000);
      tick(); idle();
      if (dut_vec() !== exp_vec() || mq.size() != 15) begin
         n_bad++;
         $display("FAIL fill_drop: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      re1 = 1; re2 = 1;
      tick(); idle();
      if (dut_vec() !== exp_vec() || ful !== 1'b0) begin
         n_bad++;
         $display("FAIL fill_read2: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      drain();
   endtask

   task automatic test_wrap();
      drain();
      for (int k = 0; k < 40 && (mw % DEPTH) != DEPTH - 1; k++) begin
         idle(); we1 = 1; wi1 = 32'h5000 + k; wpc = 32'h8000 + k * 4;
         tick();
         idle(); re1 = 1;
         tick();
      end
      idle(); wr2(32'hA, 32'hB, 32'h9000);
      tick(); idle();
      if (dut_vec() !== exp_vec() || ri1 !== 32'hA || ri2 !== 32'hB) begin
         n_bad++;
         $display("FAIL wrap_write: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      re1 = 1; re2 = 1;
      tick(); idle();
      if (dut_vec() !== exp_vec() || emp !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_read: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      we1 = 1; wi1 = 32'hC; wpc = 32'h9100;
      tick(); idle();
      if (dut_vec() !== exp_vec() || ri1 !== 32'hC) begin
         n_bad++;
         $display("FAIL wrap_after: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      drain();
   endtask

   task automatic test_simultaneous();
      idle(); wr2(32'h31, 32'h32, 32'h400);
      tick();
      idle(); we1 = 1; wi1 = 32'h33; wpc = 32'h408;
      tick();
      idle(); wr2(32'h34, 32'h35, 32'h40C); re1 = 1; re2 = 1;
      tick(); idle();
      if (dut_vec() !== exp_vec() || ri1 !== 32'h33 || mq.size() != 3) begin
         n_bad++;
         $display("FAIL simul: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      drain();
   endtask

   task automatic test_flush();
      idle(); wr2(32'h61, 32'h62, 32'h600);
      tick();
      wr2(32'h63, 32'h64, 32'h608);
      tick();
      idle(); we1 = 1; wi1 = 32'h65; wpc = 32'h610;
      tick(); idle();
      if (dut_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL flush_pre: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      flush = 1; wr2(32'h66, 32'h67, 32'h614); re1 = 1;
      tick(); idle();
      if (dut_vec() !== exp_vec() || emp !== 1'b1 || v1 !== 1'b0) begin
         n_bad++;
         $display("FAIL flush: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
   endtask

   task automatic test_illegal();
      idle(); we2 = 1; wi2 = 32'h77; wpc = 32'h700;
      tick(); idle();
      if (dut_vec() !== exp_vec() || emp !== 1'b1) begin
         n_bad++;
         $display("FAIL we2_only: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      wr2(32'h78, 32'h79, 32'h710);
      tick(); idle();
      re2 = 1;
      tick(); idle();
      if (dut_vec() !== exp_vec() || mq.size() != 2) begin
         n_bad++;
         $display("FAIL re2_only: got %h want %h", dut_vec(), exp_vec());
      end
      n_cmp++;
      drain();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         rst   = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 49) == 0);
         we1   = ($urandom_range(0, 3) != 0);
         we2   = ($urandom_range(0, 2) != 0);
         re1   = ($urandom_range(0, 9) < (k % 200 < 100 ? 3 : 8));
         re2   = ($urandom_range(0, 1) != 0);
         wi1   = $urandom;
         wi2   = $urandom;
         wpc   = {$urandom} & 32'hFFFF_FFFC;
         tick();
         if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random%0d: got %h want %h", k,
                     dut_vec(), exp_vec());
         end
         n_cmp++;
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_dual_write();
      test_fill();
      test_wrap();
      test_simultaneous();
      test_flush();
      test_illegal();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
